pixel_write_arbiter: RTL and testbench

Merges pixel-write streams from two drawing engines, the card drawer and the symbol drawer, into the single x/y/colour/plot port of the VGA adapter. It sits directly downstream of both drawers and directly upstream of the VGA adapter. It replaces the plain OR of write enables with a round-robin, back-pressured arbiter and a small pixel FIFO, so that simultaneous writes are never lost or corrupted.

---
 rtl/pixel_write_arbiter_pkg.sv | 19 +
 rtl/pixel_write_arbiter_if.sv | 37 +++
 rtl/pixel_write_arbiter_fifo.sv | 60 ++++++
 rtl/pixel_write_arbiter.sv | 87 ++++++++
 tb/tb_pixel_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_write_arbiter_pkg.sv
// Shared widths, pixel record and port identifiers for the pixel write arbiter.
package pixel_write_arbiter_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/pixel_write_arbiter_if.sv
// Bundles the card drawer (A), symbol drawer (B) and VGA adapter signals.
interface pixel_write_arbiter_if;
  import pixel_write_arbiter_pkg::*;

  logic           a_valid;
  logic           a_ready;
  logic [X_W-1:0] a_x;
  logic [Y_W-1:0] a_y;
  logic [C_W-1:0] a_colour;

  logic           b_valid;
  logic           b_ready;
  logic [X_W-1:0] b_x;
  logic [Y_W-1:0] b_y;
  logic [C_W-1:0] b_colour;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [C_W-1:0] colour;
  logic           plot;
  logic           idle;

  modport slave (
    input  a_valid, a_x, a_y, a_colour,
    input  b_valid, b_x, b_y, b_colour,
    output a_ready, b_ready,
    output x, y, colour, plot, idle
  );

  modport master (
    output a_valid, a_x, a_y, a_colour,
    output b_valid, b_x, b_y, b_colour,
    input  a_ready, b_ready,
    input  x, y, colour, plot, idle
  );

endinterface

// File: rtl/pixel_write_arbiter_fifo.sv
// Small pixel FIFO: storage, wrapping pointers and occupancy count.
module pixel_write_arbiter_fifo
  import pixel_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   i_push,
  input  pixel_t i_din,
  input  logic   i_pop,
  output pixel_t o_dout,
  output logic   o_full,
  output logic   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  pixel_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];

  // Storage is left unreset so it can map onto plain distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin merge of two drawer pixel streams into the VGA adapter write port.
module pixel_write_arbiter
  import pixel_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_pop_stall,
  pixel_write_arbiter_if.slave bus
);

  port_e          r_last_grant;
  port_e          w_grant;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  pixel_t         w_push_pixel;
  pixel_t         w_head;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [C_W-1:0] r_colour;
  logic           r_plot;

  // On contention the port that did not win last time is favoured.
  always_comb begin
    w_grant = PORT_A;
    if (bus.a_valid && bus.b_valid) begin
      w_grant = (r_last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (bus.b_valid) begin
      w_grant = PORT_B;
    end
  end

  always_comb begin
    w_push_pixel = '{x: bus.a_x, y: bus.a_y, colour: bus.a_colour};
    if (w_grant == PORT_B) begin
      w_push_pixel = '{x: bus.b_x, y: bus.b_y, colour: bus.b_colour};
    end
  end

  assign bus.a_ready = reset_n && !w_full && bus.a_valid && (w_grant == PORT_A);
  assign bus.b_ready = reset_n && !w_full && bus.b_valid && (w_grant == PORT_B);
  assign w_push      = (bus.a_valid && bus.a_ready) || (bus.b_valid && bus.b_ready);
  assign w_pop       = !w_empty && !i_pop_stall;

  pixel_write_arbiter_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_push_pixel),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_grant <= PORT_B;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
    end else begin
      if (w_push) begin
        r_last_grant <= w_grant;
      end
      if (w_pop) begin
        r_x      <= w_head.x;
        r_y      <= w_head.y;
        r_colour <= w_head.colour;
      end
      r_plot <= w_pop;
    end
  end

  assign bus.x      = r_x;
  assign bus.y      = r_y;
  assign bus.colour = r_colour;
  assign bus.plot   = r_plot;
  assign bus.idle   = w_empty && !r_plot;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed self-checking bench for pixel_write_arbiter with hand-computed expectations.
module tb_pixel_write_arbiter;
  import pixel_write_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic stall;
  int   nChecks = 0;
  int   nFails  = 0;
  int   idx;

  // Expected a_ready / plot / plotted pixel index per cycle of the wrap-around run.
  bit expReady [17] = '{1,1,1,1,1,1,1,0,1,0,1,0,0,0,0,0,0};
  bit expPlot  [17] = '{0,0,1,0,1,0,1,0,1,0,1,0,1,1,1,1,0};
  int expIdx   [17] = '{0,0,0,0,1,0,2,0,3,0,4,0,5,6,7,8,0};

  pixel_write_arbiter_if bus();

  pixel_write_arbiter #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_pop_stall (stall),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic nextEdge();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int av, input int ax, input int ay, input int ac,
                               input int bv, input int bx, input int by, input int bc);
    bus.a_valid  = (av != 0);
    bus.a_x      = X_W'(ax);
    bus.a_y      = Y_W'(ay);
    bus.a_colour = C_W'(ac);
    bus.b_valid  = (bv != 0);
    bus.b_x      = X_W'(bx);
    bus.b_y      = Y_W'(by);
    bus.b_colour = C_W'(bc);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkPixel(input string tag, input int ex, input int ey, input int ec);
    checkOutput({tag, ".plot"}, int'(bus.plot), 1);
    checkOutput({tag, ".x"}, int'(bus.x), ex);
    checkOutput({tag, ".y"}, int'(bus.y), ey);
    checkOutput({tag, ".colour"}, int'(bus.colour), ec);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] pixel_write_arbiter directed test starting");
    reset_n = 1'b0;
    stall   = 1'b0;
    applyStimulus(1, 1, 1, 1, 1, 2, 2, 2);

    // Reset held with both ports requesting
    nextEdge();
    applyStimulus(1, 1, 1, 1, 1, 2, 2, 2);
    checkOutput("rst.a_ready", int'(bus.a_ready), 0);
    checkOutput("rst.b_ready", int'(bus.b_ready), 0);
    checkOutput("rst.plot", int'(bus.plot), 0);
    checkOutput("rst.x", int'(bus.x), 0);
    checkOutput("rst.y", int'(bus.y), 0);
    checkOutput("rst.colour", int'(bus.colour), 0);
    checkOutput("rst.idle", int'(bus.idle), 1);
    nextEdge();
    applyStimulus(1, 1, 1, 1, 1, 2, 2, 2);
    checkOutput("rst2.a_ready", int'(bus.a_ready), 0);
    checkOutput("rst2.idle", int'(bus.idle), 1);
    nextEdge();
    reset_n = 1'b1;
    applyStimulus(1, 1, 1, 1, 1, 2, 2, 2);
    checkOutput("first.a_ready", int'(bus.a_ready), 1);
    checkOutput("first.b_ready", int'(bus.b_ready), 0);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("first.plot0", int'(bus.plot), 0);
    checkOutput("first.idle0", int'(bus.idle), 0);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("first.out", 1, 1, 1);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("first.plotEnd", int'(bus.plot), 0);
    checkOutput("first.idleEnd", int'(bus.idle), 1);
    checkOutput("first.xHold", int'(bus.x), 1);

    // Single port streaming
    nextEdge();
    applyStimulus(1, 10, 20, 3, 0, 0, 0, 0);
    checkOutput("single0.a_ready", int'(bus.a_ready), 1);
    nextEdge();
    applyStimulus(1, 11, 20, 3, 0, 0, 0, 0);
    checkOutput("single1.a_ready", int'(bus.a_ready), 1);
    checkOutput("single1.plot", int'(bus.plot), 0);
    nextEdge();
    applyStimulus(1, 12, 20, 3, 0, 0, 0, 0);
    checkOutput("single2.a_ready", int'(bus.a_ready), 1);
    checkPixel("single2", 10, 20, 3);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("single3", 11, 20, 3);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("single4", 12, 20, 3);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("single5.plot", int'(bus.plot), 0);
    checkOutput("single5.idle", int'(bus.idle), 1);

    // Fresh reset so the contention run starts with A favoured
    nextEdge();
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextEdge();
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pulse.idle", int'(bus.idle), 1);

    // Contention: grants alternate A,B,A,B
    nextEdge();
    applyStimulus(1, 50, 30, 1, 1, 70, 30, 2);
    checkOutput("cont0.a_ready", int'(bus.a_ready), 1);
    checkOutput("cont0.b_ready", int'(bus.b_ready), 0);
    nextEdge();
    applyStimulus(1, 50, 30, 1, 1, 70, 30, 2);
    checkOutput("cont1.a_ready", int'(bus.a_ready), 0);
    checkOutput("cont1.b_ready", int'(bus.b_ready), 1);
    checkOutput("cont1.plot", int'(bus.plot), 0);
    nextEdge();
    applyStimulus(1, 50, 30, 1, 1, 70, 30, 2);
    checkOutput("cont2.a_ready", int'(bus.a_ready), 1);
    checkOutput("cont2.b_ready", int'(bus.b_ready), 0);
    checkPixel("cont2", 50, 30, 1);
    nextEdge();
    applyStimulus(1, 50, 30, 1, 1, 70, 30, 2);
    checkOutput("cont3.a_ready", int'(bus.a_ready), 0);
    checkOutput("cont3.b_ready", int'(bus.b_ready), 1);
    checkPixel("cont3", 70, 30, 2);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("cont4", 50, 30, 1);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("cont5", 70, 30, 2);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("cont6.idle", int'(bus.idle), 1);

    // Full and back-pressure with the pop stalled
    nextEdge();
    stall = 1'b1;
    applyStimulus(1, 20, 1, 1, 1, 40, 2, 2);
    checkOutput("full0.a_ready", int'(bus.a_ready), 1);
    nextEdge();
    applyStimulus(1, 21, 1, 1, 1, 40, 2, 2);
    checkOutput("full1.b_ready", int'(bus.b_ready), 1);
    nextEdge();
    applyStimulus(1, 21, 1, 1, 1, 41, 2, 2);
    checkOutput("full2.a_ready", int'(bus.a_ready), 1);
    nextEdge();
    applyStimulus(1, 22, 1, 1, 1, 41, 2, 2);
    checkOutput("full3.b_ready", int'(bus.b_ready), 1);
    nextEdge();
    applyStimulus(1, 22, 1, 1, 1, 42, 2, 2);
    checkOutput("full4.a_ready", int'(bus.a_ready), 0);
    checkOutput("full4.b_ready", int'(bus.b_ready), 0);
    checkOutput("full4.plot", int'(bus.plot), 0);
    nextEdge();
    applyStimulus(1, 22, 1, 1, 1, 42, 2, 2);
    checkOutput("full5.a_ready", int'(bus.a_ready), 0);
    checkOutput("full5.b_ready", int'(bus.b_ready), 0);
    checkOutput("full5.idle", int'(bus.idle), 0);
    nextEdge();
    stall = 1'b0;
    applyStimulus(1, 22, 1, 1, 1, 42, 2, 2);
    checkOutput("full6.a_ready", int'(bus.a_ready), 0);
    checkOutput("full6.b_ready", int'(bus.b_ready), 0);
    checkOutput("full6.plot", int'(bus.plot), 0);
    nextEdge();
    applyStimulus(1, 22, 1, 1, 1, 42, 2, 2);
    checkOutput("full7.a_ready", int'(bus.a_ready), 1);
    checkOutput("full7.b_ready", int'(bus.b_ready), 0);
    checkPixel("full7", 20, 1, 1);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("full8", 40, 2, 2);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("full9", 21, 1, 1);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("full10", 41, 2, 2);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPixel("full11", 22, 1, 1);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full12.plot", int'(bus.plot), 0);
    checkOutput("full12.idle", int'(bus.idle), 1);

    // Wrap-around: nine pixels from A with the pop stalled every other cycle
    idx = 0;
    for (int k = 0; k < 17; k++) begin
      nextEdge();
      stall = (k < 12) && (k % 2 == 0);
      if (idx < 9) begin
        applyStimulus(1, 60 + idx, 10, idx % 8, 0, 0, 0, 0);
      end else begin
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      end
      checkOutput("wrap.a_ready", int'(bus.a_ready), int'(expReady[k]));
      checkOutput("wrap.plot", int'(bus.plot), int'(expPlot[k]));
      if (expPlot[k]) begin
        checkOutput("wrap.x", int'(bus.x), 60 + expIdx[k]);
        checkOutput("wrap.y", int'(bus.y), 10);
        checkOutput("wrap.colour", int'(bus.colour), expIdx[k] % 8);
      end
      if (expReady[k]) begin
        idx++;
      end
    end
    checkOutput("wrap.idle", int'(bus.idle), 1);

    // Mid-stream reset with three pixels queued
    nextEdge();
    stall = 1'b1;
    applyStimulus(1, 90, 5, 5, 0, 0, 0, 0);
    checkOutput("mid0.a_ready", int'(bus.a_ready), 1);
    nextEdge();
    applyStimulus(1, 91, 5, 5, 0, 0, 0, 0);
    checkOutput("mid1.a_ready", int'(bus.a_ready), 1);
    nextEdge();
    applyStimulus(1, 92, 5, 5, 0, 0, 0, 0);
    checkOutput("mid2.a_ready", int'(bus.a_ready), 1);
    nextEdge();
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mid3.plot", int'(bus.plot), 0);
    checkOutput("mid3.idle", int'(bus.idle), 0);
    nextEdge();
    reset_n = 1'b1;
    stall   = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mid4.plot", int'(bus.plot), 0);
    checkOutput("mid4.idle", int'(bus.idle), 1);
    checkOutput("mid4.x", int'(bus.x), 0);
    for (int k = 0; k < 3; k++) begin
      nextEdge();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("midAfter.plot", int'(bus.plot), 0);
      checkOutput("midAfter.idle", int'(bus.idle), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
